switch_debounce: RTL

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 60 ++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Five-channel debouncer for active-low ext-board switches.
// Each channel has a 2-flop synchronizer, a persistence counter and registered press/release pulses.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:1] nSwitch,
  output logic [5:1] nSwitchClean,
  output logic [5:1] pressed,
  output logic [5:1] released
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [5:1]    sync1;
  logic [5:1]    sync2;
  logic [CW-1:0] count [1:5];
  logic [5:1]    differ;
  logic [5:1]    expire;

  // A channel accepts its new level on the edge where the disagreement
  // has already been counted DEBOUNCE_CYCLES-1 times.
  always_comb begin
    differ = '0;
    expire = '0;
    for (int unsigned i = 1; i <= 5; i++) begin
      differ[i] = sync2[i] ^ nSwitchClean[i];
      expire[i] = differ[i] && (count[i] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= '1;
      sync2        <= '1;
      nSwitchClean <= '1;
      pressed      <= '0;
      released     <= '0;
      for (int unsigned i = 1; i <= 5; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync1        <= nSwitch;
      sync2        <= sync1;
      nSwitchClean <= nSwitchClean ^ expire;
      pressed      <= expire & nSwitchClean;
      released     <= expire & ~nSwitchClean;
      for (int unsigned i = 1; i <= 5; i++) begin
        if (!differ[i] || expire[i]) begin
          count[i] <= '0;
        end else begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

endmodule
